responder_iter: RTL
===================

# responder_iter

Multiple-response resolver for the content-addressable parallel processor. Sits directly downstream of `tags`. On command it snapshots the 100-bit tag vector and emits the index of every set tag, lowest first, one per valid/ready handshake. Word-parallel search results become a serial stream of responder addresses for read-out or per-word follow-up.

## Interface
- `N_WORDS`, 100: number of cells / tag bits.
- `IDX_W`, 7: index width; must satisfy 2^IDX_W ≥ N_WORDS.
- `CNT_W`, 7: responder count width; must satisfy 2^CNT_W ≥ N_WORDS+1.

- `CLK`  in  1  clock, rising edge.
- `RST_N`  in  1  reset, asynchronous assert, active-low.
- `tag_wires`  in  N_WORDS  tag vector from `tags`; bit i = word i responds.
- `start`  in  1  capture `tag_wires` and begin iteration.
- `busy`  out  1  high in every state except IDLE.
- `some`  out  1  snapshot still holds at least one unreported responder.
- `idx_valid`  out  1  `idx` holds a responder index.
- `idx`  out  IDX_W  index of the lowest unreported responder.
- `idx_ready`  in  1  consumer accepts `idx` this cycle.
- `count`  out  CNT_W  responders reported since the last accepted `start`.
- `done`  out  1  single-cycle pulse at end of iteration.

## Operation
- State register: IDLE, SCAN, DONE.
- Registered state: `pending` (N_WORDS), `count`, state.
- Reset: state=IDLE; `pending`=0; `count`=0.
- Reset output values: `busy`=0, `some`=0, `idx_valid`=0, `idx`=0, `done`=0, `count`=0.
- IDLE with `start`=1:
  - `pending` ← `tag_wires`; `count` ← 0.
  - If `tag_wires` is non-zero, go to SCAN; otherwise go to DONE.
- IDLE with `start`=0: hold all registers.
- SCAN:
  - `idx_valid`=1.
  - `idx` = position of the least-significant set bit of `pending`. It is combinational from registers only and never depends on `idx_ready`.
  - On `idx_valid && idx_ready`: clear that bit of `pending` and increment `count`.
  - If the cleared bit was the last set bit, go to DONE; otherwise stay in SCAN.
  - Without `idx_ready`: `idx` and `idx_valid` hold stable.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `count` holds its final value until the next accepted `start`.
- `some` = (`pending` ≠ 0) in every state.
- `idx` = 0 whenever `idx_valid`=0.
- `start` is ignored outside IDLE. Changes on `tag_wires` after capture have no effect.
- Bits of `tag_wires` at or above N_WORDS do not exist. `count` never exceeds N_WORDS and never wraps.

## Timing
- `start` sampled high in IDLE at edge k:
  - `busy` and `idx_valid` rise after edge k, with the first index visible in cycle k+1.
  - For an empty snapshot, `done` is high in cycle k+1 and `idx_valid` never rises.
- Throughput: one index per cycle while `idx_ready` is held high.
  - M responders with `idx_ready` tied high: `idx_valid` lasts M cycles, `done` follows in the next cycle, and IDLE is reached one cycle after that.
- `start` asserted in the DONE cycle is dropped. The controller re-asserts it in IDLE.
- `RST_N` low mid-SCAN returns all outputs to their reset values immediately, without waiting for `CLK`. The partially consumed snapshot is discarded.
- No combinational path from `idx_ready` or `start` to any output.

## Structure
- Shared package `capp_pkg` holds:
  - `N_WORDS`, `IDX_W`, `CNT_W` defaults.
  - State encoding constants `ST_IDLE`, `ST_SCAN`, `ST_DONE`.
- Sub-module `lsb_prio_enc` (parameter N_WORDS):
  - Input vector; outputs the index of the lowest set bit and an `any` flag.
  - Instantiated once on `pending`.
  - Reusable by `tags` select-first logic.

## Test plan
- Reset mid-SCAN: `pending`={5,9}, assert `RST_N`=0 between edges → all outputs 0 immediately, no `done` pulse; after release, state is IDLE.
- Empty snapshot: `tag_wires`=0, `start`=1 → next cycle `done`=1, `count`=0, `idx_valid` never high, `busy` high for exactly one cycle.
- Three responders with ready tied high: `tag_wires` bits {3,17,99} set, `idx_ready`=1 → `idx`=3,17,99 on consecutive cycles; then `done`=1 with `count`=3.
- Backpressure: bits {0,64} set, `idx_ready` low for 4 cycles then high → `idx`=0 stable for 5 cycles before acceptance, then `idx`=64; `tag_wires` changed to all-ones during iteration has no effect.
- Full vector: all 100 bits set, ready high → indices 0..99 in order, `count`=100 at `done`, `some` falls in the same cycle `done` rises.
- Ignored start: `start` held high throughout a two-responder run including the DONE cycle → no re-capture until IDLE; second run begins the cycle after IDLE is entered.

Source files
------------

// File: rtl/capp_pkg.sv
// Shared sizing defaults and controller state encoding for the
// content-addressable parallel processor blocks.
package capp_pkg;
  localparam int N_WORDS = 100;
  localparam int IDX_W   = 7;
  localparam int CNT_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder: index of the least-significant 1 plus an
// any-set flag. idx is 0 when no bit is set.
module lsb_prio_enc #(
  parameter int N_WORDS = 100,
  parameter int IDX_W   = 7
) (
  input  logic [N_WORDS-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  // Scan high-to-low so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N_WORDS - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;
endmodule

// File: rtl/responder_iter.sv
// Multiple-response resolver: snapshots the tag vector on start and streams
// out the index of every set tag, lowest first, one per valid/ready handshake.
module responder_iter #(
  parameter int N_WORDS = capp_pkg::N_WORDS,
  parameter int IDX_W   = capp_pkg::IDX_W,
  parameter int CNT_W   = capp_pkg::CNT_W
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N_WORDS-1:0] tag_wires,
  input  logic               start,
  output logic               busy,
  output logic               some,
  output logic               idx_valid,
  output logic [IDX_W-1:0]   idx,
  input  logic               idx_ready,
  output logic [CNT_W-1:0]   count,
  output logic               done
);
  import capp_pkg::*;

  state_t             state_q, state_d;
  logic [N_WORDS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [IDX_W-1:0]   enc_idx;
  logic               enc_any;
  logic [N_WORDS-1:0] pending_next;

  lsb_prio_enc #(.N_WORDS(N_WORDS), .IDX_W(IDX_W)) u_enc (
    .vec (pending_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  // x & (x-1) drops exactly the lowest set bit, i.e. the one being reported.
  assign pending_next = pending_q & (pending_q - N_WORDS'(1));

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pending_d = tag_wires;
          count_d   = '0;
          state_d   = (|tag_wires) ? ST_SCAN : ST_DONE;
        end
      end
      ST_SCAN: begin
        if (idx_ready) begin
          pending_d = pending_next;
          count_d   = count_q + CNT_W'(1);
          if (pending_next == '0) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign some      = enc_any;
  assign idx_valid = (state_q == ST_SCAN);
  assign idx       = idx_valid ? enc_idx : '0;
  assign count     = count_q;
  assign done      = (state_q == ST_DONE);
endmodule
